// File: rtl/cpu_pkg.sv
// Shared codes for the write-back stage: write-back selectors, load funct3 values
// and the writer FSM state encoding.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        WB_NONE = 2'b00,
        WB_ALU  = 2'b01,
        WB_LOAD = 2'b10,
        WB_PC4  = 2'b11
    } wb_sel_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wr_state_e;

endpackage

// File: rtl/regfile_writer_load_formatter.sv
// Combinational load formatter: selects the byte/half at the load offset from a
// word-aligned response and sign- or zero-extends it according to funct3.
module load_formatter
    import cpu_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] data,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection; halfword loads ignore addr_lo[0]
    always_comb begin
        byte_s = 8'h00;
        case (addr_lo)
            2'b00:   byte_s = data[7:0];
            2'b01:   byte_s = data[15:8];
            2'b10:   byte_s = data[23:16];
            2'b11:   byte_s = data[31:24];
            default: byte_s = 8'h00;
        endcase
        if (addr_lo[1]) begin
            half_s = data[31:16];
        end else begin
            half_s = data[15:0];
        end
    end

    // Extension by load type; unknown encodings write zero
    always_comb begin
        result = 32'h0000_0000;
        case (funct3)
            F3_LB:   result = {{24{byte_s[7]}}, byte_s};
            F3_LH:   result = {{16{half_s[15]}}, half_s};
            F3_LW:   result = data;
            F3_LBU:  result = {24'h00_0000, byte_s};
            F3_LHU:  result = {16'h0000, half_s};
            default: result = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/regfile_writer.sv
// Write-back front end driving the register file write port from retiring MEM
// instructions. Optional RETIRE_COUNT_EN adds a retired-instruction counter port.
module regfile_writer
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_AW-1:0] in_rd,
    input  logic [1:0]        in_wb_sel,
    input  logic [2:0]        in_funct3,
    input  logic [1:0]        in_addr_lo,
    input  logic [XLEN-1:0]   in_alu_result,
    input  logic [XLEN-1:0]   in_pc4,
    input  logic              mem_rsp_valid,
    input  logic [XLEN-1:0]   mem_rsp_data,
    output logic              isWrite,
    output logic [REG_AW-1:0] rd,
    output logic [XLEN-1:0]   writeData
`ifdef RETIRE_COUNT_EN
    ,
    output logic [31:0]       retire_count
`endif
);

    wr_state_e         state_r, nxt_state_s;
    logic              iswrite_r, nxt_iswrite_s;
    logic [REG_AW-1:0] rd_r, nxt_rd_s;
    logic [XLEN-1:0]   wdata_r, nxt_wdata_s;
    logic [REG_AW-1:0] ld_rd_r, nxt_ld_rd_s;
    logic [2:0]        ld_f3_r, nxt_ld_f3_s;
    logic [1:0]        ld_addr_r, nxt_ld_addr_s;
    logic [XLEN-1:0]   ld_result_s;
    logic              xfer_s;

    assign in_ready  = (state_r == ST_IDLE);
    assign xfer_s    = in_valid && in_ready;
    assign isWrite   = iswrite_r;
    assign rd        = rd_r;
    assign writeData = wdata_r;

    load_formatter u_fmt (
        .funct3  (ld_f3_r),
        .addr_lo (ld_addr_r),
        .data    (mem_rsp_data),
        .result  (ld_result_s)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= nxt_state_s;
        end
    end

    // FSM next-state: a load parks the writer until its response arrives
    always_comb begin
        nxt_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s && (in_wb_sel == WB_LOAD)) begin
                    nxt_state_s = ST_WAIT_MEM;
                end else begin
                    nxt_state_s = ST_IDLE;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    nxt_state_s = ST_IDLE;
                end else begin
                    nxt_state_s = ST_WAIT_MEM;
                end
            end
            default: nxt_state_s = ST_IDLE;
        endcase
    end

    // FSM outputs: next write-port values and the latched load context
    always_comb begin
        nxt_iswrite_s = 1'b0;
        nxt_rd_s      = rd_r;
        nxt_wdata_s   = wdata_r;
        nxt_ld_rd_s   = ld_rd_r;
        nxt_ld_f3_s   = ld_f3_r;
        nxt_ld_addr_s = ld_addr_r;
        case (state_r)
            ST_IDLE: begin
                if (xfer_s) begin
                    case (wb_sel_e'(in_wb_sel))
                        WB_ALU: begin
                            nxt_iswrite_s = (in_rd != {REG_AW{1'b0}});
                            nxt_rd_s      = in_rd;
                            nxt_wdata_s   = in_alu_result;
                        end
                        WB_PC4: begin
                            nxt_iswrite_s = (in_rd != {REG_AW{1'b0}});
                            nxt_rd_s      = in_rd;
                            nxt_wdata_s   = in_pc4;
                        end
                        WB_LOAD: begin
                            nxt_ld_rd_s   = in_rd;
                            nxt_ld_f3_s   = in_funct3;
                            nxt_ld_addr_s = in_addr_lo;
                        end
                        WB_NONE: nxt_iswrite_s = 1'b0;
                        default: nxt_iswrite_s = 1'b0;
                    endcase
                end else begin
                    nxt_iswrite_s = 1'b0;
                end
            end
            ST_WAIT_MEM: begin
                if (mem_rsp_valid) begin
                    nxt_iswrite_s = (ld_rd_r != {REG_AW{1'b0}});
                    nxt_rd_s      = ld_rd_r;
                    nxt_wdata_s   = ld_result_s;
                end else begin
                    nxt_iswrite_s = 1'b0;
                end
            end
            default: nxt_iswrite_s = 1'b0;
        endcase
    end

    // Write-port and load-context registers
    always_ff @(posedge clk) begin
        if (rst) begin
            iswrite_r <= 1'b0;
            rd_r      <= {REG_AW{1'b0}};
            wdata_r   <= {XLEN{1'b0}};
            ld_rd_r   <= {REG_AW{1'b0}};
            ld_f3_r   <= 3'b000;
            ld_addr_r <= 2'b00;
        end else begin
            iswrite_r <= nxt_iswrite_s;
            rd_r      <= nxt_rd_s;
            wdata_r   <= nxt_wdata_s;
            ld_rd_r   <= nxt_ld_rd_s;
            ld_f3_r   <= nxt_ld_f3_s;
            ld_addr_r <= nxt_ld_addr_s;
        end
    end

`ifdef RETIRE_COUNT_EN
    logic        retire_s;
    logic [31:0] retire_cnt_r;

    // Loads retire with their write; everything else with its transfer
    assign retire_s = (xfer_s && (in_wb_sel != WB_LOAD)) ||
                      ((state_r == ST_WAIT_MEM) && mem_rsp_valid);
    assign retire_count = retire_cnt_r;

    // Retired-instruction counter, wraps naturally
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt_r <= 32'h0000_0000;
        end else if (retire_s) begin
            retire_cnt_r <= retire_cnt_r + 32'h0000_0001;
        end else begin
            retire_cnt_r <= retire_cnt_r;
        end
    end
`endif

endmodule

// File: tb/tb_regfile_writer.sv
// Scoreboard bench for regfile_writer: the driver pushes expected writes, a
// negedge monitor pops and compares every isWrite pulse.
module tb_regfile_writer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [4:0]  in_rd = 5'd0;
    logic [1:0]  in_wb_sel = 2'b00;
    logic [2:0]  in_funct3 = 3'b000;
    logic [1:0]  in_addr_lo = 2'b00;
    logic [31:0] in_alu_result = 32'h0;
    logic [31:0] in_pc4 = 32'h0;
    logic        mem_rsp_valid = 1'b0;
    logic [31:0] mem_rsp_data = 32'h0;
    logic        isWrite;
    logic [4:0]  rd;
    logic [31:0] writeData;
`ifdef RETIRE_COUNT_EN
    logic [31:0] retire_count;
`endif

    int          n_cmp = 0;
    int          n_err = 0;
    logic [36:0] exp_q[$];
    logic [36:0] exp_e;
    logic [31:0] exp_retire = 32'h0;

    regfile_writer dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_wb_sel     (in_wb_sel),
        .in_funct3     (in_funct3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .in_pc4        (in_pc4),
        .mem_rsp_valid (mem_rsp_valid),
        .mem_rsp_data  (mem_rsp_data),
        .isWrite       (isWrite),
        .rd            (rd),
        .writeData     (writeData)
`ifdef RETIRE_COUNT_EN
        ,
        .retire_count  (retire_count)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference load result from plain shifts and range tests
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] d);
        logic [31:0] b, h;
        b = (d >> (8 * a)) & 32'h0000_00FF;
        h = (d >> (16 * a[1])) & 32'h0000_FFFF;
        case (f3)
            3'd0:    return (b >= 32'h80)   ? b + 32'hFFFF_FF00 : b;
            3'd1:    return (h >= 32'h8000) ? h + 32'hFFFF_0000 : h;
            3'd2:    return d;
            3'd4:    return b;
            3'd5:    return h;
            default: return 32'h0;
        endcase
    endfunction

    // Monitor: every write pulse must match the oldest expected write
    always @(negedge clk) begin
        if (!rst) begin
            if (isWrite) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_write: got rd=%0d data=%h, required no write", rd, writeData);
                end else begin
                    exp_e = exp_q.pop_front();
                    check("write_rd_data", {27'd0, rd, writeData}, {27'd0, exp_e});
                end
            end
`ifdef RETIRE_COUNT_EN
            check("retire_count", {32'd0, retire_count}, {32'd0, exp_retire});
`endif
        end
    end

    // Issue one instruction; loads get their response after dly idle cycles
    task automatic send(input logic [1:0] sel, input logic [4:0] r, input logic [2:0] f3,
                        input logic [1:0] a, input logic [31:0] alu, input logic [31:0] pc4,
                        input int dly, input logic [31:0] rspd, input logic [31:0] expd);
        in_valid      = 1'b1;
        in_wb_sel     = sel;
        in_rd         = r;
        in_funct3     = f3;
        in_addr_lo    = a;
        in_alu_result = alu;
        in_pc4        = pc4;
        mem_rsp_valid = 1'($urandom_range(0, 1));
        mem_rsp_data  = $urandom;
        @(negedge clk);
        check("in_ready_idle", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        in_valid      = 1'b0;
        mem_rsp_valid = 1'b0;
        if (sel != 2'b10) begin
            exp_retire = exp_retire + 32'd1;
            if (sel != 2'b00 && r != 5'd0) exp_q.push_back({r, expd});
        end else begin
            for (int i = 0; i < dly; i++) begin
                in_valid  = 1'($urandom_range(0, 1));
                in_wb_sel = 2'($urandom);
                in_rd     = 5'($urandom);
                @(negedge clk);
                check("in_ready_wait", {63'd0, in_ready}, 64'd0);
                @(posedge clk); #1;
            end
            in_valid      = 1'b0;
            mem_rsp_valid = 1'b1;
            mem_rsp_data  = rspd;
            if (r != 5'd0) exp_q.push_back({r, expd});
            @(negedge clk);
            check("in_ready_rsp", {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            mem_rsp_valid = 1'b0;
            exp_retire    = exp_retire + 32'd1;
        end
    endtask

    initial begin
        logic [1:0]  sel;
        logic [4:0]  r;
        logic [2:0]  f3;
        logic [1:0]  a;
        logic [31:0] alu, pc4, d;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_isWrite",   {63'd0, isWrite}, 64'd0);
        check("reset_rd",        {59'd0, rd}, 64'd0);
        check("reset_writeData", {32'd0, writeData}, 64'd0);
        check("reset_in_ready",  {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;

        send(2'b01, 5'd5, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 0, 32'h0, 32'hDEAD_BEEF);
        repeat (2) @(posedge clk); #1;
        send(2'b01, 5'd1, 3'd0, 2'd0, 32'h1111_1111, 32'h0, 0, 32'h0, 32'h1111_1111);
        send(2'b01, 5'd2, 3'd0, 2'd0, 32'h2222_2222, 32'h0, 0, 32'h0, 32'h2222_2222);
        send(2'b01, 5'd3, 3'd0, 2'd0, 32'h3333_3333, 32'h0, 0, 32'h0, 32'h3333_3333);
        send(2'b10, 5'd9,  3'b000, 2'd3, 32'h0, 32'h0, 3, 32'h8000_0000, 32'hFFFF_FF80);
        send(2'b10, 5'd10, 3'b100, 2'd3, 32'h0, 32'h0, 3, 32'h8000_0000, 32'h0000_0080);
        send(2'b10, 5'd11, 3'b101, 2'd2, 32'h0, 32'h0, 1, 32'hABCD_1234, 32'h0000_ABCD);
        send(2'b10, 5'd12, 3'b001, 2'd0, 32'h0, 32'h0, 0, 32'h0000_8001, 32'hFFFF_8001);
        send(2'b11, 5'd0,  3'd0, 2'd0, 32'h5, 32'h1234, 0, 32'h0, 32'h0);
        send(2'b00, 5'd7,  3'd0, 2'd0, 32'h6, 32'h7, 0, 32'h0, 32'h0);
        repeat (2) @(posedge clk); #1;

        // Reset while a load is outstanding, then a late response
        in_valid = 1'b1; in_wb_sel = 2'b10; in_rd = 5'd7; in_funct3 = 3'b010;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_retire = 32'h0;
        mem_rsp_valid = 1'b1; mem_rsp_data = 32'hCAFE_F00D;
        @(negedge clk);
        check("rst_wait_in_ready",  {63'd0, in_ready}, 64'd1);
        check("rst_wait_isWrite",   {63'd0, isWrite}, 64'd0);
        check("rst_wait_rd",        {59'd0, rd}, 64'd0);
        check("rst_wait_writeData", {32'd0, writeData}, 64'd0);
        @(posedge clk); #1;
        mem_rsp_valid = 1'b0;
        @(negedge clk);
        check("late_rsp_isWrite", {63'd0, isWrite}, 64'd0);
        @(posedge clk); #1;

        for (int n = 0; n < 300; n++) begin
            sel = 2'($urandom);
            r   = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            f3  = 3'($urandom);
            a   = 2'($urandom);
            alu = $urandom;
            pc4 = $urandom;
            d   = $urandom;
            case (sel)
                2'b01:   send(sel, r, f3, a, alu, pc4, 0, d, alu);
                2'b11:   send(sel, r, f3, a, alu, pc4, 0, d, pc4);
                2'b10:   send(sel, r, f3, a, alu, pc4, $urandom_range(0, 4), d, ref_load(f3, a, d));
                default: send(sel, r, f3, a, alu, pc4, 0, d, 32'h0);
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
